// File: rtl/riscv_display_ctrl.sv
// riscv_display_ctrl: VGA timing, per-frame PC/instruction snapshot and
// run/single-step CPU enable gating aligned to vertical blanking.
// Ports: clk, reset (sync, active-high), run, step (async inputs),
//   pc_in/inst_in (live CPU state), cpu_en (one-cycle advance),
//   hsync/vsync (active-low), video_on, pixel_row/pixel_column,
//   frame_start (vblank pulse), pc_disp/inst_disp (frozen values).
// Optional: define RISCV_DISP_STEP_DEBOUNCE_EN to debounce step.
module riscv_display_ctrl #(
`ifdef RISCV_DISP_STEP_DEBOUNCE_EN
   parameter int DEBOUNCE_CYCLES = 250000,
`endif
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        step,
   input  logic [31:0] pc_in,
   input  logic [31:0] inst_in,
   output logic        cpu_en,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [9:0]  pixel_row,
   output logic [9:0]  pixel_column,
   output logic        frame_start,
   output logic [31:0] pc_disp,
   output logic [31:0] inst_disp
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
   localparam int VW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      WAIT_REL
   } step_state_t;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_wrap;
   logic          step_slot;
   logic          snap_slot;
   logic          run_m, run_s;
   logic          step_m, step_s;
   logic          step_lvl, step_lvl_prev;
   logic          step_rise;
   step_state_t   state;

   assign h_wrap    = (h_cnt == HW'(H_TOTAL - 1));
   assign step_slot = (h_cnt == '0) && (v_cnt == VW'(V_VISIBLE));
   assign snap_slot = (h_cnt == '0) && (v_cnt == VW'(V_VISIBLE + V_FP));

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
         if (h_wrap)
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end
   end

   // Decoded from the counters and registered so all timing outputs
   // share the same one-cycle lag.
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync        <= 1'b1;
         vsync        <= 1'b1;
         video_on     <= 1'b0;
         pixel_row    <= '0;
         pixel_column <= '0;
         frame_start  <= 1'b0;
      end else begin
         hsync <= !((h_cnt >= HW'(H_VISIBLE + H_FP)) &&
                    (h_cnt <  HW'(H_VISIBLE + H_FP + H_SYNC)));
         vsync <= !((v_cnt >= VW'(V_VISIBLE + V_FP)) &&
                    (v_cnt <  VW'(V_VISIBLE + V_FP + V_SYNC)));
         video_on     <= (h_cnt < HW'(H_VISIBLE)) &&
                         (v_cnt < VW'(V_VISIBLE));
         pixel_column <= h_cnt[9:0];
         pixel_row    <= v_cnt[9:0];
         frame_start  <= step_slot;
      end
   end

   // Snapshot late in vblank, after the cpu_en advance at step_slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_disp   <= '0;
         inst_disp <= '0;
      end else if (snap_slot) begin
         pc_disp   <= pc_in;
         inst_disp <= inst_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_m  <= 1'b0;
         run_s  <= 1'b0;
         step_m <= 1'b0;
         step_s <= 1'b0;
      end else begin
         run_m  <= run;
         run_s  <= run_m;
         step_m <= step;
         step_s <= step_m;
      end
   end

`ifdef RISCV_DISP_STEP_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [DW-1:0] db_cnt;

   // The debounced level flips only after the synchronized input has
   // differed from it for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_cnt   <= '0;
         step_lvl <= 1'b0;
      end else if (step_s == step_lvl) begin
         db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
         db_cnt   <= '0;
         step_lvl <= step_s;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end
`else
   assign step_lvl = step_s;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         step_lvl_prev <= 1'b0;
      else
         step_lvl_prev <= step_lvl;
   end

   assign step_rise = step_lvl && !step_lvl_prev;

   // step_slot fires once per frame, so cpu_en can never be high
   // on two consecutive cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cpu_en <= 1'b0;
      end else if (run_s) begin
         cpu_en <= step_slot;
         if (state != IDLE)
            state <= WAIT_REL;
      end else begin
         cpu_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (step_rise)
                  state <= ARMED;
            end
            ARMED: begin
               if (step_slot) begin
                  cpu_en <= 1'b1;
                  state  <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (!step_lvl)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_display_ctrl.sv
// tb_riscv_display_ctrl: directed bench for riscv_display_ctrl
// using a 14 x 7 (98-cycle) frame.
module tb_riscv_display_ctrl;

   localparam int FRAME = 98;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        step;
   logic [31:0] pc_in;
   logic [31:0] inst_in;
   logic        cpu_en;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic [9:0]  pixel_row;
   logic [9:0]  pixel_column;
   logic        frame_start;
   logic [31:0] pc_disp;
   logic [31:0] inst_disp;

   int n;
   int errors;
   int checks;

   riscv_display_ctrl #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .step(step),
      .pc_in(pc_in),
      .inst_in(inst_in),
      .cpu_en(cpu_en),
      .hsync(hsync),
      .vsync(vsync),
      .video_on(video_on),
      .pixel_row(pixel_row),
      .pixel_column(pixel_column),
      .frame_start(frame_start),
      .pc_disp(pc_disp),
      .inst_disp(inst_disp)
   );

   always #5 clk = ~clk;

   // Sample n sees outputs decoded from counter value n-1.
   task automatic tick();
      @(posedge clk);
      #1;
      n = n + 1;
   endtask

   task automatic align(input int off);
      while ((n % FRAME) != off)
         tick();
   endtask

   task automatic check_reset_vals(input string tag);
      checks = checks + 1;
      if ({hsync, vsync, video_on, frame_start, cpu_en} !== 5'b11000) begin
         errors = errors + 1;
         $display("FAIL %s flags got=%b want=11000", tag,
                  {hsync, vsync, video_on, frame_start, cpu_en});
      end
      checks = checks + 1;
      if ({pixel_row, pixel_column} !== 20'd0) begin
         errors = errors + 1;
         $display("FAIL %s pixel got=%0d/%0d want=0/0", tag,
                  pixel_row, pixel_column);
      end
      checks = checks + 1;
      if ({pc_disp, inst_disp} !== 64'd0) begin
         errors = errors + 1;
         $display("FAIL %s disp got=%h/%h want=0/0", tag,
                  pc_disp, inst_disp);
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      run     = 1'b0;
      step    = 1'b0;
      pc_in   = 32'd0;
      inst_in = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      reset = 1'b0;
      n = 0;
   endtask

   task automatic test_timing();
      int c, h, v;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         c = n - 1;
         h = c % 14;
         v = (c / 14) % 7;
         checks = checks + 1;
         if (hsync !== !(h == 10 || h == 11)) begin
            errors = errors + 1;
            $display("FAIL hsync n=%0d got=%b want=%b", n, hsync,
                     !(h == 10 || h == 11));
         end
         checks = checks + 1;
         if (vsync !== (v != 5)) begin
            errors = errors + 1;
            $display("FAIL vsync n=%0d got=%b want=%b", n, vsync, v != 5);
         end
         checks = checks + 1;
         if (video_on !== (h < 8 && v < 4)) begin
            errors = errors + 1;
            $display("FAIL video_on n=%0d got=%b want=%b", n, video_on,
                     h < 8 && v < 4);
         end
         checks = checks + 1;
         if (pixel_column !== 10'(h) || pixel_row !== 10'(v)) begin
            errors = errors + 1;
            $display("FAIL pixel n=%0d got=%0d/%0d want=%0d/%0d", n,
                     pixel_row, pixel_column, v, h);
         end
         checks = checks + 1;
         if (frame_start !== ((n % FRAME) == 57)) begin
            errors = errors + 1;
            $display("FAIL frame_start n=%0d got=%b want=%b", n,
                     frame_start, (n % FRAME) == 57);
         end
         checks = checks + 1;
         if (cpu_en !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL idle_cpu_en n=%0d got=%b want=0", n, cpu_en);
         end
      end
   endtask

   task automatic test_single_step();
      int p, pulses;
      for (int press = 0; press < 2; press++) begin
         align(10);
         step = 1'b1;
         p = n + 47;
         pulses = 0;
         for (int i = 0; i < 300; i++) begin
            tick();
            if (cpu_en === 1'b1) pulses = pulses + 1;
            checks = checks + 1;
            if (cpu_en !== (n == p)) begin
               errors = errors + 1;
               $display("FAIL step_pulse n=%0d got=%b want=%b", n,
                        cpu_en, n == p);
            end
         end
         checks = checks + 1;
         if (pulses !== 1) begin
            errors = errors + 1;
            $display("FAIL step_count got=%0d want=1", pulses);
         end
         step = 1'b0;
         for (int i = 0; i < 200; i++) begin
            tick();
            checks = checks + 1;
            if (cpu_en !== 1'b0) begin
               errors = errors + 1;
               $display("FAIL step_release n=%0d got=%b want=0", n, cpu_en);
            end
         end
      end
   endtask

   task automatic test_run_mode();
      int pulses;
      align(10);
      run = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5 * FRAME; i++) begin
         tick();
         if ((n % 7) == 0) step = ~step;
         if (cpu_en === 1'b1) pulses = pulses + 1;
         checks = checks + 1;
         if (cpu_en !== ((n % FRAME) == 57)) begin
            errors = errors + 1;
            $display("FAIL run_pulse n=%0d got=%b want=%b", n, cpu_en,
                     (n % FRAME) == 57);
         end
      end
      checks = checks + 1;
      if (pulses !== 5) begin
         errors = errors + 1;
         $display("FAIL run_count got=%0d want=5", pulses);
      end
      step = 1'b0;
      repeat (5) tick();
      run = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         checks = checks + 1;
         if (cpu_en !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL run_off n=%0d got=%b want=0", n, cpu_en);
         end
      end
   endtask

   task automatic test_snapshot();
      logic [31:0] old_pc, old_inst, new_pc, new_inst, exp_pc, exp_inst;
      bit snapped;
      for (int phase = 0; phase < 2; phase++) begin
         if (phase == 0) begin
            align(30);
            old_pc = 32'd0;
            old_inst = 32'd0;
            new_pc = 32'h0000_0004;
            new_inst = 32'h0050_0093;
         end else begin
            old_pc = 32'h0000_0004;
            old_inst = 32'h0050_0093;
            new_pc = 32'h0000_0008;
            new_inst = 32'h00a0_0113;
         end
         pc_in = new_pc;
         inst_in = new_inst;
         snapped = 1'b0;
         for (int i = 0; i < ((phase == 0) ? 60 : FRAME); i++) begin
            tick();
            if ((n % FRAME) == 71) snapped = 1'b1;
            exp_pc = snapped ? new_pc : old_pc;
            exp_inst = snapped ? new_inst : old_inst;
            checks = checks + 1;
            if (pc_disp !== exp_pc || inst_disp !== exp_inst) begin
               errors = errors + 1;
               $display("FAIL snapshot n=%0d got=%h/%h want=%h/%h", n,
                        pc_disp, inst_disp, exp_pc, exp_inst);
            end
         end
      end
   endtask

   task automatic test_reset_armed();
      align(10);
      step = 1'b1;
      align(55);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks = checks + 1;
         if (cpu_en !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_armed_en i=%0d got=%b want=0", i, cpu_en);
         end
      end
      check_reset_vals("reset_armed");
      step = 1'b0;
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         checks = checks + 1;
         if (cpu_en !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_armed_idle n=%0d got=%b want=0", n, cpu_en);
         end
         checks = checks + 1;
         if (frame_start !== ((n % FRAME) == 57)) begin
            errors = errors + 1;
            $display("FAIL reset_armed_fs n=%0d got=%b want=%b", n,
                     frame_start, (n % FRAME) == 57);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      n = 0;
      test_reset();
      test_timing();
      test_single_step();
      test_run_mode();
      test_snapshot();
      test_reset_armed();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
